// File: rtl/serial_demux_rx_pkg.sv
// Shared constants, channel ids and FSM state encoding for the serial demux receiver.
// The optional parity bit is selected with the SERIAL_RX_PARITY_EN macro.
package serial_demux_rx_pkg;

    localparam int BUFF_SIZE        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    // ST_PARITY is only ever entered when SERIAL_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_CHAN      = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_e;

endpackage

// File: rtl/serial_demux_rx_if.sv
// Serial line input plus the two demultiplexed channel outputs, error pulses and FSM state.
// valid_1/valid_2 are one-cycle strobes with no ready: the consumer must capture data_out_x
// in the cycle its strobe is high; the two strobes are never high together.
interface serial_demux_rx_if
    import serial_demux_rx_pkg::*;
#(
    parameter int DATA_W = BUFF_SIZE
);

    logic              rx;
    logic [DATA_W-1:0] data_out_1;
    logic              valid_1;
    logic [DATA_W-1:0] data_out_2;
    logic              valid_2;
    logic              frame_err;
    logic              parity_err;
    logic              busy;
    rx_state_e         state;

    modport master (
        input  rx,
        output data_out_1, valid_1, data_out_2, valid_2,
        output frame_err, parity_err, busy, state
    );

    modport slave (
        output rx,
        input  data_out_1, valid_1, data_out_2, valid_2,
        input  frame_err, parity_err, busy, state
    );

endinterface

// File: rtl/serial_demux_rx_bit_timer.sv
// Free-running bit timer: half_tick marks mid start bit, full_tick marks mid of later bits.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_demux_rx.sv
// Deserialises the dual-channel serial link and steers each word to its channel output.
// Define SERIAL_RX_PARITY_EN to expect an even parity bit over channel + data bits.
module serial_demux_rx
    import serial_demux_rx_pkg::*;
#(
    parameter int DATA_W       = BUFF_SIZE,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input logic              clk,
    input logic              rst_n,
    serial_demux_rx_if.master bus
);

    localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic              sync_1, sync_2;
    rx_state_e         state, state_nxt;
    logic              timer_clr, half_tick, full_tick;
    logic [DATA_W-1:0] shreg, data_1, data_2;
    logic [IDX_W-1:0]  bit_idx;
    logic              chan, par_bad;
    logic              valid_1_q, valid_2_q, ferr_q, perr_q;
    logic              load_1, load_2, ferr_set, perr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= bus.rx;
            sync_2 <= sync_1;
        end
    end

    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        load_1    = 1'b0;
        load_2    = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (!sync_2) state_nxt = ST_START;
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (half_tick) begin
                    timer_clr = 1'b1;
                    state_nxt = sync_2 ? ST_IDLE : ST_CHAN;
                end
            end
            ST_CHAN: if (full_tick) state_nxt = ST_DATA;
            ST_DATA: begin
                if (full_tick && bit_idx == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: if (full_tick) state_nxt = ST_STOP;
`endif
            ST_STOP: begin
                if (full_tick) begin
                    perr_set = par_bad;
                    if (!sync_2) begin
                        ferr_set  = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end else begin
                        state_nxt = ST_IDLE;
                        load_1    = !par_bad && (chan == CH1);
                        load_2    = !par_bad && (chan == CH2);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                timer_clr = 1'b1;
                if (sync_2) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
            chan    <= CH1;
        end else begin
            if (state == ST_IDLE) bit_idx <= '0;
            if (state == ST_CHAN && full_tick) chan <= sync_2;
            if (state == ST_DATA && full_tick) begin
                shreg   <= {sync_2, shreg[DATA_W-1:1]};
                bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic par_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc <= 1'b0;
            par_bad <= 1'b0;
        end else if (state == ST_IDLE) begin
            par_acc <= 1'b0;
            par_bad <= 1'b0;
        end else if (full_tick) begin
            if (state == ST_CHAN)   par_acc <= sync_2;
            if (state == ST_DATA)   par_acc <= par_acc ^ sync_2;
            if (state == ST_PARITY) par_bad <= par_acc ^ sync_2;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_1    <= '0;
            data_2    <= '0;
            valid_1_q <= 1'b0;
            valid_2_q <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (load_1) data_1 <= shreg;
            if (load_2) data_2 <= shreg;
            valid_1_q <= load_1;
            valid_2_q <= load_2;
            ferr_q    <= ferr_set;
            perr_q    <= perr_set;
        end
    end

    assign bus.data_out_1 = data_1;
    assign bus.valid_1    = valid_1_q;
    assign bus.data_out_2 = data_2;
    assign bus.valid_2    = valid_2_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.state      = state;

endmodule

// File: tb/tb_serial_demux_rx.sv
// Directed + randomised frames against a frame-level reference model of serial_demux_rx.
module tb_serial_demux_rx;
    import serial_demux_rx_pkg::*;

    localparam int DW = 8;
    localparam int C  = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT = 2 + C / 2 + (DW + 2 + P) * C;

    logic clk, rst_n;
    serial_demux_rx_if #(.DATA_W(DW)) bus ();

    serial_demux_rx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [40:0] exp_q[$];          // {expected cycle, channel, data}
    logic [DW-1:0] last_1 = '0, last_2 = '0;
    int exp_ferr = 0, exp_perr = 0;
    int ferr_cnt = 0, perr_cnt = 0, v1_cnt = 0, v2_cnt = 0;
    logic prev_v1 = 0, prev_v2 = 0, prev_ferr = 0, prev_perr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_1 || bus.valid_2) begin
                logic [40:0] e;
                logic        ch;
                logic [DW-1:0] d;
                check("valid_exclusive", {bus.valid_1, bus.valid_2}, bus.valid_2 ? 2'b01 : 2'b10);
                ch = bus.valid_2;
                d  = bus.valid_2 ? bus.data_out_2 : bus.data_out_1;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {ch, d}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_cyc_ch_data", {cyc, ch, d}, e);
                end
            end
            if (bus.valid_1) begin v1_cnt++; check("valid_1_width", prev_v1, 0); end
            if (bus.valid_2) begin v2_cnt++; check("valid_2_width", prev_v2, 0); end
            if (bus.frame_err)  begin ferr_cnt++; check("frame_err_width", prev_ferr, 0); end
            if (bus.parity_err) begin perr_cnt++; check("parity_err_width", prev_perr, 0); end
        end
        prev_v1   = bus.valid_1;
        prev_v2   = bus.valid_2;
        prev_ferr = bus.frame_err;
        prev_perr = bus.parity_err;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (C) @(negedge clk);
    endtask

    // Sends one frame; the model decides from frame rules what the receiver must report.
    task automatic send_frame(input logic ch, input logic [DW-1:0] d,
                              input logic flip_par, input logic stop_val);
        logic par, par_fault, good;
        par       = (^{ch, d}) ^ flip_par;
        par_fault = (P == 1) && flip_par;
        good      = stop_val && !par_fault;
        if (good) begin
            exp_q.push_back({cyc + 32'd1 + 32'(LAT), ch, d});
            if (ch) last_2 = d; else last_1 = d;
        end
        if (!stop_val) exp_ferr++;
        if (par_fault) exp_perr++;
        drive_bit(1'b0);
        drive_bit(ch);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (P == 1) drive_bit(par);
        drive_bit(stop_val);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_q_empty"}, exp_q.size(), 0);
        check({tag, "_data_out_1"}, bus.data_out_1, last_1);
        check({tag, "_data_out_2"}, bus.data_out_2, last_2);
        check({tag, "_frame_err_cnt"}, ferr_cnt, exp_ferr);
        check({tag, "_parity_err_cnt"}, perr_cnt, exp_perr);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data_out_1", bus.data_out_1, 0);
        check("reset_data_out_2", bus.data_out_2, 0);
        check("reset_strobes", {bus.valid_1, bus.valid_2, bus.frame_err, bus.parity_err}, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_state", bus.state, ST_IDLE);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single ch1 frame
        send_frame(CH1, 8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_outputs("s1");
        check("s1_valid_1_count", v1_cnt, 1);
        check("s1_valid_2_count", v2_cnt, 0);
        check("s1_busy", bus.busy, 0);

        // 2: back-to-back, no idle
        send_frame(CH1, 8'h01, 1'b0, 1'b1);
        send_frame(CH2, 8'h02, 1'b0, 1'b1);
        send_frame(CH1, 8'h03, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_outputs("s2");
        check("s2_valid_counts", {v1_cnt, v2_cnt}, {32'd3, 32'd1});

        // 3: 4-cycle glitch on rx
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        check("s3_busy_during_glitch", bus.busy, 1);
        bus.rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("s3_busy_after", bus.busy, 0);
        check_outputs("s3");
        check("s3_valid_counts", {v1_cnt, v2_cnt}, {32'd3, 32'd1});

        // 4: bad stop bit then held break
        send_frame(CH2, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (25) @(negedge clk);
            check("s4_wait_idle", bus.state, ST_WAIT_IDLE);
        end
        bus.rx = 1'b1;
        repeat (C) @(negedge clk);
        check("s4_idle_after_release", bus.state, ST_IDLE);
        send_frame(CH2, 8'h55, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_outputs("s4");

`ifdef SERIAL_RX_PARITY_EN
        // 5: parity flipped
        send_frame(CH1, 8'h0F, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_outputs("s5");
        check("s5_valid_1_count", v1_cnt, 3);
`endif

        // 6: reset in the middle of DATA
        drive_bit(1'b0);
        drive_bit(CH2);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("s6_busy", bus.busy, 0);
        check("s6_state", bus.state, ST_IDLE);
        check("s6_outputs", {bus.data_out_1, bus.data_out_2, bus.valid_1, bus.valid_2,
                             bus.frame_err, bus.parity_err}, 0);
        last_1 = '0;
        last_2 = '0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(CH2, 8'h81, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_outputs("s6");

        // Random traffic with occasional stop/parity faults.
        for (int n = 0; n < 24; n++) begin
            logic ch, fp, bad_stop;
            logic [DW-1:0] d;
            int gap;
            ch       = 1'($urandom_range(0, 1));
            d        = DW'($urandom_range(0, 255));
            bad_stop = ($urandom_range(0, 5) == 0);
            fp       = ($urandom_range(0, 5) == 0);
            gap      = $urandom_range(0, 2 * C);
            send_frame(ch, d, fp, !bad_stop);
            if (bad_stop) begin
                bus.rx = 1'b1;
                gap = gap + 4;
            end
            repeat (gap) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check_outputs("random");
        check("random_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_demux_rx.md
# serial_demux_rx

Receive-side counterpart of the dual-channel serial transmitter. Deserializes the single `tx` line from the `Top` transmitter, identifies which of the two source FIFOs a frame came from, and presents each word on its own channel output with a one-cycle valid strobe. Sits at the far end of the link and feeds the two consumer-side buffers.

## Interface
Parameters:
- `DATA_W`, default `` `BUFF_SIZE `` (8): payload width per frame.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be even and ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `data_out_1`  out  `DATA_W`  last word received for channel 1.
- `valid_1`  out  1  one-cycle strobe; `data_out_1` was updated this cycle.
- `data_out_2`  out  `DATA_W`  last word received for channel 2.
- `valid_2`  out  1  one-cycle strobe for channel 2.
- `frame_err`  out  1  one-cycle pulse; stop bit was sampled low.
- `parity_err`  out  1  one-cycle pulse; parity mismatch. Tied 0 when parity is compiled out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame format, in order: start (0), channel bit (0 = ch1, 1 = ch2), `DATA_W` data bits LSB first, optional parity bit, stop (1).
- `rx` passes through a 2-flop synchronizer, reset to 1. All FSM decisions use the synchronized value.
- States: IDLE, START, CHAN, DATA, PARITY (present only with the macro), STOP, WAIT_IDLE.
- IDLE: when sync rx = 0, go to START and clear the bit-timer.
- START: after `CLKS_PER_BIT/2` cycles, sample. A 0 means go to CHAN with the timer cleared. A 1 means the edge was a glitch; return to IDLE with no error.
- Every later bit is sampled when the bit-timer reaches `CLKS_PER_BIT-1`; the timer then wraps to 0.
- CHAN: latch the channel bit.
- DATA: shift in `DATA_W` bits. The bit index counts 0..`DATA_W-1`, then moves to PARITY or STOP.
- STOP, sample = 1, no parity error: load `data_out_x` for the latched channel, pulse `valid_x`, go to IDLE.
- STOP, sample = 0: pulse `frame_err`, drop the word, go to WAIT_IDLE.
- WAIT_IDLE: stay until sync rx = 1, then go to IDLE. A held-low line (break) never re-triggers.
- `data_out_x` holds its value between frames. `valid_1` and `valid_2` are never high in the same cycle.
- Reset mid-frame: the FSM returns to IDLE at once and the partial word is discarded.

## Timing
- All outputs reset to 0, including `data_out_1` and `data_out_2`. Synchronizer flops reset to 1. The FSM resets to IDLE.
- `valid_x`, `frame_err` and `parity_err` are registered and last exactly one cycle.
- Latency: let edge 0 be the clock edge at which the first synchronizer flop captures rx = 0. `valid_x` is high in the cycle after edge `2 + CLKS_PER_BIT/2 + (DATA_W + 2 + P) * CLKS_PER_BIT`, where P = 1 if parity is enabled.
- The receiver is back in IDLE in the same cycle `valid_x` goes high. A start bit immediately following the stop bit is therefore accepted; back-to-back frames lose no data.
- Tolerates ±3% clock mismatch between transmitter and receiver at `CLKS_PER_BIT` = 16.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - The PARITY state exists. It expects even parity over the channel bit and the data bits.
  - On mismatch: pulse `parity_err` at the STOP sample, suppress `valid_x`, go to IDLE (or WAIT_IDLE if the stop bit is also 0, with both error pulses raised).
- Not defined:
  - No parity bit is expected, so the frame is `DATA_W` + 3 bits.
  - `parity_err` is constant 0.
- The transmitter must be built with the same setting.

## Structure
- Shared package / `params.vh` holds:
  - `BUFF_SIZE` and the default `CLKS_PER_BIT`.
  - The FSM state encoding.
  - The channel-id constants `CH1 = 0` and `CH2 = 1`.
- One sub-module, `rx_bit_timer`:
  - Clear input; produces a `half_tick` pulse (count `CLKS_PER_BIT/2-1`) and a `full_tick` pulse (count `CLKS_PER_BIT-1`).
- The synchronizer, shift register and FSM live in the top module.

## Test plan
Defaults for all scenarios: `DATA_W`=8, `CLKS_PER_BIT`=16, parity on.
1. Send frame ch1, 0xA5 → `valid_1` pulses once at the specified latency; `data_out_1`=0xA5; `data_out_2` stays 0.
2. Send ch1 0x01, ch2 0x02, ch1 0x03 back-to-back with no idle time → strobes appear in that order with those values; no errors.
3. Pulse rx low for 4 cycles, then return high → back to IDLE; no valid and no error outputs.
4. Send ch2 0x3C with stop bit = 0, then hold rx low for 100 cycles, then release → one `frame_err` pulse; FSM stays in WAIT_IDLE while low; the next good frame (ch2 0x55) is received.
5. Send ch1 0x0F with the parity bit flipped → one `parity_err` pulse, no `valid_1`, `data_out_1` unchanged.
6. Assert `rst_n` low in the middle of the DATA state of ch2 0xFF → all outputs 0 and `busy`=0 immediately; a following ch2 0x81 frame is received correctly.
